// File: rtl/parity_shift_ctrl.sv
// parity_shift_ctrl
// Captures one parity vector from the encoder core and presents it a byte at
// a time on L[7:0] to the parity byte-output stage. L shifts right by one
// byte per accepted beat. The block also drives that stage's counter enable
// and clear, and checks the stage's done flag against its own byte count.
module parity_shift_ctrl #(
    parameter int DATA_W = 1024,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              parity_valid,
    input  logic [DATA_W-1:0] parity_in,
    output logic              parity_ready,
    input  logic              out_ready,
    input  logic              abort,
    input  logic              parity_out_done,
    output logic [DATA_W-1:0] L,
    output logic              en_counterOUT,
    output logic              rst_c,
    output logic              d_valid,
    output logic [7:0]        byte_cnt,
    output logic              frame_done,
    output logic              err
);

    localparam int         NBYTES   = DATA_W / BYTE_W;
    localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] l_q, l_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              err_q, err_d;
    logic              beat;

    // A beat moves one byte to the sink. The shift and the downstream counter
    // enable share this one term, which keeps the two counts aligned.
    assign beat = (state_q == SHIFT) && out_ready && !abort;

    // Next-state and datapath update; abort takes priority over a beat.
    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (parity_valid) begin
                    l_d        = parity_in;
                    byte_cnt_d = 8'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The output stage must not report done before the last byte.
                if (parity_out_done) begin
                    err_d = 1'b1;
                end
                if (abort) begin
                    // L and byte_cnt are left as they were for inspection.
                    state_d = IDLE;
                end else if (beat) begin
                    l_d        = {{BYTE_W{1'b0}}, l_q[DATA_W-1:BYTE_W]};
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    if (byte_cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // The output stage must agree that the frame is complete.
                if (!parity_out_done) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register, byte count and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            l_q        <= '0;
            byte_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

    // Handshake and sequencing outputs decode from the registered state only;
    // the counter enable additionally qualifies with the live beat condition.
    assign parity_ready  = (state_q == IDLE);
    assign d_valid       = (state_q == SHIFT);
    assign en_counterOUT = beat;
    assign rst_c         = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign L             = l_q;
    assign byte_cnt      = byte_cnt_q;
    assign err           = err_q;

endmodule

// File: tb/tb_parity_shift_ctrl.sv
// Self-checking bench for parity_shift_ctrl. A frame-level reference model
// (original vector, count of accepted bytes, phase) predicts every output;
// the presented byte is the original vector shifted by 8*count.
module tb_parity_shift_ctrl;

    localparam int W = 1024;
    localparam int PH_IDLE  = 0;
    localparam int PH_SHIFT = 1;
    localparam int PH_DONE  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         parity_valid = 1'b0;
    logic [W-1:0] parity_in = '0;
    logic         parity_ready;
    logic         out_ready = 1'b0;
    logic         abort = 1'b0;
    logic         parity_out_done = 1'b0;
    logic [W-1:0] L;
    logic         en_counterOUT;
    logic         rst_c;
    logic         d_valid;
    logic [7:0]   byte_cnt;
    logic         frame_done;
    logic         err;

    parity_shift_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .parity_valid    (parity_valid),
        .parity_in       (parity_in),
        .parity_ready    (parity_ready),
        .out_ready       (out_ready),
        .abort           (abort),
        .parity_out_done (parity_out_done),
        .L               (L),
        .en_counterOUT   (en_counterOUT),
        .rst_c           (rst_c),
        .d_valid         (d_valid),
        .byte_cnt        (byte_cnt),
        .frame_done      (frame_done),
        .err             (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_phase;
    logic [W-1:0] m_vec;
    int           m_cnt;
    bit           m_err;
    int           m_dcnt;   // downstream output-stage counter

    // Observations from the most recent step
    bit           o_en;
    bit           o_fd;
    logic [7:0]   o_b;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_vec   = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_dcnt  = 0;
    endtask

    // One clock cycle: drive inputs, check all outputs, advance the model.
    // podm: 0 = done flag from downstream counter model, 1 = forced 0, 2 = forced 1
    task automatic step(input bit pv, input logic [W-1:0] pin, input bit ordy, input bit ab, input int podm);
        bit pod;
        bit e_en;
        @(negedge clk);
        parity_valid = pv;
        parity_in    = pin;
        out_ready    = ordy;
        abort        = ab;
        pod = (podm == 0) ? (m_dcnt == 128) : (podm == 2);
        parity_out_done = pod;
        #1;
        e_en = (m_phase == PH_SHIFT) && ordy && !ab;
        check_val("parity_ready", W'(parity_ready), W'(m_phase == PH_IDLE));
        check_val("d_valid", W'(d_valid), W'(m_phase == PH_SHIFT));
        check_val("en_counterOUT", W'(en_counterOUT), W'(e_en));
        check_val("rst_c", W'(rst_c), W'(m_phase != PH_IDLE));
        check_val("frame_done", W'(frame_done), W'(m_phase == PH_DONE));
        check_val("byte_cnt", W'(byte_cnt), W'(m_cnt));
        check_val("err", W'(err), W'(m_err));
        check_val("L", L, m_vec >> (8 * m_cnt));
        o_en = en_counterOUT;
        o_fd = frame_done;
        o_b  = L[7:0];
        // downstream counter: synchronous clear while rst_c low, else count beats
        if (m_phase == PH_IDLE) m_dcnt = 0;
        else if (e_en) m_dcnt++;
        case (m_phase)
            PH_IDLE: if (pv) begin
                m_vec   = pin;
                m_cnt   = 0;
                m_phase = PH_SHIFT;
            end
            PH_SHIFT: begin
                if (pod) m_err = 1'b1;
                if (ab) m_phase = PH_IDLE;
                else if (ordy) begin
                    m_cnt++;
                    if (m_cnt == 128) m_phase = PH_DONE;
                end
            end
            default: begin
                if (!pod) m_err = 1'b1;
                m_phase = PH_IDLE;
            end
        endcase
    endtask

    task automatic sync_release_reset();
        @(negedge clk);
        parity_valid = 1'b0;
        out_ready    = 1'b0;
        abort        = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] v_inc;
    logic [W-1:0] v_ff;
    logic [W-1:0] v_r;
    logic [W-1:0] captured;
    int           en_cnt, done_cyc, beats, bad;
    bit           seen_done, cap_pending;
    logic [1:0]   bp_pat;

    initial begin
        for (int k = 0; k < 128; k++) v_inc[8*k +: 8] = 8'(k);
        v_ff = '1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state held with no stimulus
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b0, 1'b0, 0);

        // Byte order with out_ready tied high; load cycle is cycle 1
        en_cnt = 0; done_cyc = 0; bad = 0;
        step(1'b1, v_inc, 1'b1, 1'b0, 0);
        for (int c = 2; c <= 135; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, 0);
            if (o_en) begin
                if (o_b != 8'(en_cnt)) bad++;
                en_cnt++;
            end
            if (o_fd && done_cyc == 0) done_cyc = c;
        end
        check_val("order_bytes_wrong", W'(bad), W'(0));
        check_val("order_en_cycles", W'(en_cnt), W'(128));
        check_val("order_done_cycle", W'(done_cyc), W'(130));
        check_val("order_final_cnt", W'(byte_cnt), W'(128));
        check_val("order_err", W'(err), W'(0));

        // Backpressure: out_ready 1,0,0,1 repeating
        bp_pat = 2'd0; en_cnt = 0; bad = 0; seen_done = 1'b0;
        step(1'b1, v_inc, 1'b0, 1'b0, 0);
        for (int c = 0; c < 600 && !seen_done; c++) begin
            step(1'b0, '0, (bp_pat == 2'd0 || bp_pat == 2'd3), 1'b0, 0);
            bp_pat = bp_pat + 2'd1;
            if (o_en) begin
                if (o_b != 8'(en_cnt)) bad++;
                en_cnt++;
            end
            if (o_fd) seen_done = 1'b1;
        end
        check_val("bp_bytes_wrong", W'(bad), W'(0));
        check_val("bp_beats", W'(en_cnt), W'(128));
        check_val("bp_done_seen", W'(seen_done), W'(1));

        // Abort after 40 beats, then an all-0xFF frame
        v_r = rand_vec(); beats = 0; seen_done = 1'b0;
        step(1'b1, v_r, 1'b1, 1'b0, 0);
        for (int c = 0; c < 100 && beats < 40; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, 0);
            if (o_en) beats++;
        end
        step(1'b0, '0, 1'b1, 1'b1, 0);
        if (o_fd) seen_done = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, 0);
        if (o_fd) seen_done = 1'b1;
        check_val("abort_byte_cnt", W'(byte_cnt), W'(40));
        check_val("abort_rst_c", W'(rst_c), W'(0));
        check_val("abort_no_done", W'(seen_done), W'(0));
        en_cnt = 0; bad = 0;
        step(1'b1, v_ff, 1'b1, 1'b0, 0);
        for (int c = 0; c < 135; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, 0);
            if (o_en) begin
                if (o_b != 8'hFF) bad++;
                en_cnt++;
            end
        end
        check_val("ff_bytes_wrong", W'(bad), W'(0));
        check_val("ff_beats", W'(en_cnt), W'(128));

        // Stuck-low done flag, then a clean frame: err stays set
        step(1'b1, rand_vec(), 1'b1, 1'b0, 1);
        for (int c = 0; c < 135; c++) step(1'b0, '0, 1'b1, 1'b0, 1);
        check_val("stuck_low_err", W'(err), W'(1));
        step(1'b1, rand_vec(), 1'b1, 1'b0, 0);
        for (int c = 0; c < 135; c++) step(1'b0, '0, 1'b1, 1'b0, 0);
        check_val("err_sticky", W'(err), W'(1));

        // Premature done at beat 50
        sync_release_reset();
        beats = 0;
        step(1'b1, rand_vec(), 1'b1, 1'b0, 0);
        for (int c = 0; c < 135; c++) begin
            step(1'b0, '0, 1'b1, 1'b0, (beats == 50) ? 2 : 0);
            if (o_en) beats++;
        end
        check_val("premature_done_err", W'(err), W'(1));

        // Back-to-back: parity_valid held with fresh data every cycle
        sync_release_reset();
        cap_pending = 1'b0; captured = '0; beats = 0; seen_done = 1'b0;
        for (int c = 0; c < 400 && !(seen_done && beats >= 70); c++) begin
            v_r = rand_vec();
            step(1'b1, v_r, 1'b1, 1'b0, 0);
            if (cap_pending) begin
                check_val("b2b_capture", L, captured);
                cap_pending = 1'b0;
            end
            if (o_fd) begin
                seen_done = 1'b1;
                beats = 0;
                // next cycle is the first IDLE cycle; its vector gets loaded
                v_r = rand_vec();
                step(1'b1, v_r, 1'b1, 1'b0, 0);
                captured = v_r;
                cap_pending = 1'b1;
            end else if (o_en) beats++;
        end
        check_val("b2b_done_seen", W'(seen_done), W'(1));

        // Asynchronous reset mid-frame (beat 70 of the second frame)
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_L", L, '0);
        check_val("arst_parity_ready", W'(parity_ready), W'(1));
        check_val("arst_d_valid", W'(d_valid), W'(0));
        check_val("arst_en", W'(en_counterOUT), W'(0));
        check_val("arst_rst_c", W'(rst_c), W'(0));
        check_val("arst_frame_done", W'(frame_done), W'(0));
        check_val("arst_byte_cnt", W'(byte_cnt), W'(0));
        check_val("arst_err", W'(err), W'(0));
        model_reset();
        parity_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            step(($urandom_range(0, 3) == 0), rand_vec(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_shift_ctrl.md
Name: parity_shift_ctrl

Overview:
- Upstream neighbour of the encoder's parity byte-output stage.
- Captures a full 1024-bit parity vector from the encoder core and drives the bus `L`. It shifts `L` right by one byte for each byte the sink accepts, so the output stage always presents the next byte on `L[7:0]`.
- Sequences that stage's enable and clear inputs (`en_counterOUT`, `rst_c`) and cross-checks its `parity_out_done` against an internal byte count.

Parameters:
- `DATA_W`, 1024, parity vector width in bits.
- `BYTE_W`, 8, output byte width.
- `NBYTES`, `DATA_W/BYTE_W` = 128, bytes per frame (derived; not overridden).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `parity_valid` input 1: encoder offers `parity_in`.
- `parity_in` input 1024: parity vector; bit 0 = first bit out.
- `parity_ready` output 1: block can accept a vector.
- `out_ready` input 1: sink accepts the current byte this cycle.
- `abort` input 1: synchronous frame abort.
- `parity_out_done` input 1: done flag from the output stage.
- `L` output 1024: parity shift register, fed to the output stage.
- `en_counterOUT` output 1: output-stage counter enable.
- `rst_c` output 1: output-stage synchronous clear, active-low.
- `d_valid` output 1: `L[7:0]` holds a valid byte.
- `byte_cnt` output 8: bytes accepted in the current frame.
- `frame_done` output 1: one-cycle pulse at frame completion.
- `err` output 1: sticky mismatch flag.

Behaviour:

Reset (`rst_n` low, asynchronous):
- state=`IDLE`, `L`=0, `byte_cnt`=0, `err`=0.
- Resulting outputs: `parity_ready`=1, `d_valid`=0, `en_counterOUT`=0, `rst_c`=0, `frame_done`=0.

States: `IDLE`, `SHIFT`, `DONE`, held in a registered state.

Combinational outputs, decoded from the registered state only:
- `parity_ready` = (state==`IDLE`).
- `d_valid` = (state==`SHIFT`).
- `en_counterOUT` = (state==`SHIFT`) & `out_ready` & !`abort`.
- `rst_c` = (state!=`IDLE`), so the downstream counter is held at 0 whenever idle.
- `frame_done` = (state==`DONE`).

`IDLE`:
- On `parity_valid`=1: `L`<=`parity_in`, `byte_cnt`<=0, next state=`SHIFT`.
- On `parity_valid`=0: hold.

`SHIFT`:
- On a beat (`out_ready`=1, `abort`=0):
  - `L`<={8'b0, `L`[1023:8]} (logical right shift by `BYTE_W`, zero fill).
  - `byte_cnt`<=`byte_cnt`+1.
- If that beat occurs with `byte_cnt`==127: next state=`DONE` (`byte_cnt` becomes 128).
- On `out_ready`=0: `L`, `byte_cnt` and state hold. The byte stays stable indefinitely; no timeout.

`DONE` (exactly one cycle, then `IDLE`):
- Sample `parity_out_done`. If it is 0, set `err`<=1.
- `L` holds (all-zero after 128 shifts).
- `byte_cnt` stays 128 until the next load.

Alignment:
- `L` shift and `en_counterOUT` are driven by the same beat condition. The downstream counter therefore always equals `byte_cnt` while in `SHIFT`.
- Downstream `d_out` = byte number `byte_cnt` of the original vector.

Abort:
- `abort`=1 in `SHIFT`: next state=`IDLE`, no beat, `en_counterOUT`=0, `frame_done` not pulsed.
- `L` and `byte_cnt` hold their values. The downstream counter is cleared by `rst_c`=0 in `IDLE`.
- `abort` in `IDLE` or `DONE`: ignored.

`parity_valid` outside `IDLE`:
- Ignored, since `parity_ready`=0. The encoder must hold the vector until `parity_ready`.
- `parity_in` is not captured during `DONE`. A back-to-back frame loads earliest on the cycle after `DONE`.

`parity_out_done` check:
- Also while in `SHIFT`: if `parity_out_done`=1, set `err`<=1 (premature done).

`err`:
- Cleared only by `rst_n`.

Mid-operation reset:
- Immediate return to reset values regardless of state.

Frame throughput:
- Minimum 1 (load) + 128 (shift) + 1 (done) = 130 cycles with `out_ready` tied high.

Test Plan:
- **Reset check:** reset, then release with no stimulus → `parity_ready`=1, `rst_c`=0, `d_valid`=0, `L`=0, `err`=0 for 10 cycles.
- **Byte order:** load `parity_in` with byte k = k (0x00..0x7F), `out_ready`=1 → `L[7:0]` sequence 0x00,0x01,…,0x7F on consecutive cycles. Also:
  - `en_counterOUT` high for exactly 128 cycles;
  - `frame_done` pulses on cycle 130;
  - `byte_cnt`=128;
  - model `parity_out_done` (counter==128) yields `err`=0.
- **Backpressure:** same frame with `out_ready` toggling 1,0,0,1 repeating → each byte held stable while `out_ready`=0; all 128 bytes delivered in order; `frame_done` after 128 accepted beats.
- **Abort:** assert `abort` after 40 beats → next cycle `IDLE`, `rst_c`=0, `byte_cnt`=40, no `frame_done`. A following load of all-0xFF delivers 128 bytes of 0xFF.
- **Stuck-low done:** tie `parity_out_done`=0 → `err`=1 after the `DONE` cycle and stays 1 through the next clean frame. Separately, force `parity_out_done`=1 at beat 50 → `err`=1.
- **Back-to-back load:** hold `parity_valid`=1 continuously with new data during a frame → second vector captured only on the first `IDLE` cycle after `DONE`. Assert `rst_n` low mid-frame (beat 70) → all outputs at reset values asynchronously.
